// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the analog MUX scan sequencer.
// Holds the FSM state encoding and a saturating counter helper.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        SETTLE,
        STROBE,
        NEXT
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mux_ch_finder.sv
// Rotating priority encoder: first set mask bit strictly after cur, wrapping 7->0.
// Purely combinational; cur itself is found last, so a lone set bit reports wrap.
module mux_ch_finder
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic              none
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = cur + SEL_W'(k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign none = ~|mask;
    assign wrap = !none && (nxt <= cur);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the external 8:1 MUX through masked channels: break, settle, strobe, await ack.
// First strobe SETTLE_CYCLES+2 cycles after enable; a channel in flight always completes.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              sample_ack,
    input  logic              err_clr,
    output logic              EN,
    output logic              A2,
    output logic              A1,
    output logic              A0,
    output logic              S,
    output logic              busy,
    output logic              scan_done,
    output logic              ack_err
);

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q, s_q, busy_q, done_q, err_q, err_d;
    logic [SEL_W-1:0] search_cur, nxt_ch;
    logic             nxt_wrap, mask_none, tmo_hit;

    // From IDLE, searching "after channel 7" yields the lowest set channel.
    assign search_cur = (state_q == IDLE) ? SEL_W'(NUM_CH - 1) : sel_q;

    mux_ch_finder u_finder (
        .mask (ch_mask),
        .cur  (search_cur),
        .nxt  (nxt_ch),
        .wrap (nxt_wrap),
        .none (mask_none)
    );

    assign tmo_hit = (state_q == STROBE) && !sample_ack
                     && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign err_d   = tmo_hit | (err_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_d;
            case (state_q)
                IDLE: begin
                    en_q  <= 1'b0;
                    s_q   <= 1'b0;
                    cnt_q <= '0;
                    if (enable && !mask_none) begin
                        sel_q   <= nxt_ch;
                        busy_q  <= 1'b1;
                        state_q <= BREAK;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                BREAK: begin
                    en_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q >= CNT_W'(SETTLE_CYCLES - 1)) begin
                        s_q     <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                STROBE: begin
                    if (sample_ack || tmo_hit) begin
                        s_q     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= NEXT;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                NEXT: begin
                    if (!enable || mask_none) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= nxt_wrap;
                        if (nxt_wrap && !continuous) begin
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            sel_q   <= nxt_ch;
                            en_q    <= 1'b0;
                            state_q <= BREAK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign EN           = en_q;
    assign {A2, A1, A0} = sel_q;
    assign S            = s_q;
    assign busy         = busy_q;
    assign scan_done    = done_q;
    assign ack_err      = err_q;

endmodule
